// File: rtl/pc_fetch_register.sv
// PC register and fetch sequencer: fetches the word at pc, holds it for execution,
// commits pcNext on an unstalled EXEC cycle, and traps on misalignment or fetch timeout.
module pc_fetch_register #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              MAX_WAIT     = 15
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [XLEN-1:0] pcNext,
    input  logic            stall,
    input  logic            imemReady,
    input  logic [31:0]     imemRdata,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [31:0]     instr,
    output logic            instrValid,
    output logic            halted,
    output logic            trapMisaligned,
    output logic            fetchTimeout,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] waitCnt;

    assign imemAddr = pc;
    assign pcPlus4  = pc + XLEN'(4);

    // Status outputs are registered alongside the state so they switch on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            instr          <= '0;
            instret        <= '0;
            waitCnt        <= '0;
            imemReq        <= 1'b0;
            instrValid     <= 1'b0;
            halted         <= 1'b0;
            trapMisaligned <= 1'b0;
            fetchTimeout   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
                FETCH: begin
                    if (imemReady) begin
                        instr      <= imemRdata;
                        waitCnt    <= '0;
                        state      <= EXEC;
                        imemReq    <= 1'b0;
                        instrValid <= 1'b1;
                    end else if (waitCnt == WAIT_LAST) begin
                        // Ready arriving on this same cycle would have taken the branch above.
                        waitCnt      <= waitCnt + 8'd1;
                        state        <= HALT;
                        imemReq      <= 1'b0;
                        halted       <= 1'b1;
                        fetchTimeout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        instrValid <= 1'b0;
                        if (pcNext[1:0] == 2'b00) begin
                            pc      <= pcNext;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                            imemReq <= 1'b1;
                        end else begin
                            state          <= HALT;
                            halted         <= 1'b1;
                            trapMisaligned <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_register.sv
// Randomised bench for pc_fetch_register: a transaction-level driver pushes expected
// executions into a queue and a negedge monitor compares them whenever instrValid is seen.
module tb_pc_fetch_register;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] pcNext = '0;
    logic        stall = 1'b0;
    logic        imemReady = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] instr;
    logic        instrValid;
    logic        halted;
    logic        trapMisaligned;
    logic        fetchTimeout;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [31:0] mPc  = '0;
    logic [31:0] mCnt = '0;

    pc_fetch_register #(.XLEN(32), .RESET_VECTOR(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .resetN(resetN), .pcNext(pcNext), .stall(stall),
        .imemReady(imemReady), .imemRdata(imemRdata), .imemReq(imemReq),
        .imemAddr(imemAddr), .pc(pc), .pcPlus4(pcPlus4), .instr(instr),
        .instrValid(instrValid), .halted(halted), .trapMisaligned(trapMisaligned),
        .fetchTimeout(fetchTimeout), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(string tag);
        check({tag, ".pc"}, pc, 32'h0);
        check({tag, ".pcPlus4"}, pcPlus4, 32'h4);
        check({tag, ".imemAddr"}, imemAddr, 32'h0);
        check({tag, ".instr"}, instr, 32'h0);
        check({tag, ".instret"}, instret, 32'h0);
        check({tag, ".imemReq"}, imemReq, 0);
        check({tag, ".instrValid"}, instrValid, 0);
        check({tag, ".halted"}, halted, 0);
        check({tag, ".trapMisaligned"}, trapMisaligned, 0);
        check({tag, ".fetchTimeout"}, fetchTimeout, 0);
    endtask

    task automatic applyReset();
        resetN = 1'b0;
        mPc    = '0;
        mCnt   = '0;
        expQ.delete();
        imemReady = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic waitFetch();
        int n = 0;
        while (!imemReq && n < 8) begin
            step();
            n++;
        end
        if (!imemReq) check("waitFetchReq", imemReq, 1);
    endtask

    // One instruction: w not-ready fetch cycles, s stall cycles, then offer nxt.
    task automatic doInstr(input int w, input int s, input logic [31:0] nxt, input logic [31:0] rd);
        exp_t e;
        waitFetch();
        if (!imemReq) return;
        e.pc = mPc;
        e.instr = rd;
        e.instret = mCnt;
        expQ.push_back(e);
        for (int i = 0; i < w; i++) begin
            imemReady = 1'b0;
            imemRdata = $urandom();
            stall     = 1'($urandom_range(0, 1));
            step();
        end
        imemReady = 1'b1;
        imemRdata = rd;
        pcNext    = nxt;
        stall     = 1'($urandom_range(0, 1));
        step();
        imemReady = 1'b0;
        imemRdata = $urandom();
        check("execEntry", instrValid, 1);
        for (int i = 0; i < s; i++) begin
            stall = 1'b1;
            step();
        end
        stall = 1'b0;
        step();
        if (nxt[1:0] == 2'b00) begin
            mPc  = nxt;
            mCnt = mCnt + 32'd1;
        end
        check("commitToFetch", imemReq, 32'(nxt[1:0] == 2'b00));
    endtask

    // Monitor: checks fetch address and every executing instruction against the queue.
    always @(negedge clk) begin
        if (resetN) begin
            if (imemReq) check("imemAddr", imemAddr, mPc);
            if (instrValid) begin
                if (expQ.size() == 0) begin
                    check("execWithoutExpect", instrValid, 0);
                end else begin
                    monE = expQ[0];
                    check("exec.pc", pc, monE.pc);
                    check("exec.pcPlus4", pcPlus4, monE.pc + 32'd4);
                    check("exec.instr", instr, monE.instr);
                    check("exec.instret", instret, monE.instret);
                    check("exec.imemReq", imemReq, 0);
                    check("exec.halted", halted, 0);
                    if (!stall) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] held;

        applyReset();
        step();
        step();
        checkReset("por");
        resetN = 1'b1;
        check("boot.imemReq", imemReq, 0);
        step();
        check("cycle2.imemReq", imemReq, 1);
        check("cycle2.imemAddr", imemAddr, 32'h0);

        for (int i = 0; i < 3; i++) doInstr(0, 0, mPc + 32'd4, $urandom());
        check("t1.pc", pc, 32'd12);
        check("t1.instret", instret, 32'd3);

        doInstr(3, 0, mPc + 32'd4, $urandom());
        doInstr(0, 4, mPc + 32'd4, $urandom());
        doInstr(14, 1, mPc + 32'd4, $urandom());

        for (int i = 0; i < 30; i++) begin
            r = $urandom();
            doInstr($urandom_range(0, 14), $urandom_range(0, 3), r & 32'hFFFF_FFFC, $urandom());
        end

        doInstr(0, 0, 32'hFFFF_FFFC, $urandom());
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.pcPlus4", pcPlus4, 32'h0);
        doInstr(1, 0, 32'h0, $urandom());
        check("wrap.back", pc, 32'h0);

        doInstr(1, 2, 32'd12345678, $urandom());
        check("mis.halted", halted, 1);
        check("mis.trap", trapMisaligned, 1);
        check("mis.timeout", fetchTimeout, 0);
        check("mis.pc", pc, mPc);
        check("mis.instret", instret, mCnt);
        check("mis.instrValid", instrValid, 0);
        check("mis.imemReq", imemReq, 0);
        held = instr;
        imemReady = 1'b1;
        for (int i = 0; i < 3; i++) step();
        imemReady = 1'b0;
        check("mis.frozenPc", pc, mPc);
        check("mis.frozenInstr", instr, held);
        check("mis.stillHalted", halted, 1);

        applyReset();
        #1;
        checkReset("haltReset");
        step();
        resetN = 1'b1;
        doInstr(0, 0, 32'h40, $urandom());

        waitFetch();
        imemReady = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("tmo.notYet", halted, 0);
        step();
        check("tmo.halted", halted, 1);
        check("tmo.flag", fetchTimeout, 1);
        check("tmo.trap", trapMisaligned, 0);
        check("tmo.imemReq", imemReq, 0);
        check("tmo.pc", pc, mPc);
        step();
        check("tmo.sticky", fetchTimeout, 1);

        applyReset();
        #1;
        checkReset("tmoReset");
        step();
        resetN = 1'b1;
        doInstr(2, 0, 32'h100, $urandom());
        waitFetch();
        step();
        step();
        applyReset();
        #1;
        checkReset("fetchReset");
        step();
        resetN = 1'b1;
        doInstr(0, 1, 32'h8, $urandom());
        check("restart.pc", pc, 32'h8);
        check("restart.instret", instret, 32'd1);

        step();
        check("queueDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
